// File: rtl/axi_sram_slave_pkg.sv
// Shared widths, response/burst encodings and FSM state type for the AXI-to-SRAM slave responder.
package axi_sram_slave_pkg;

  localparam int unsigned AXI_ID_W    = 8;
  localparam int unsigned AXI_ADDR_W  = 32;
  localparam int unsigned AXI_LEN_W   = 4;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_RESP_W  = 2;
  localparam int unsigned AXI_DATA_W  = 32;
  localparam int unsigned AXI_STRB_W  = AXI_DATA_W / 8;

  localparam logic [AXI_RESP_W-1:0]  RESP_OKAY   = 2'b00;
  localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;
  localparam logic [AXI_SIZE_W-1:0]  SIZE_4B     = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WDATA = 3'd3,
    S_BRESP = 3'd4
  } slave_state_t;

  // Remaining-beat counter reaches zero on the final beat of a burst.
  function automatic logic is_last_beat(input logic [AXI_LEN_W-1:0] cnt);
    return cnt == '0;
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4 slave-port bundle (AR/R/AW/W/B) between the crossbar and the SRAM responder.
interface axi_sram_slave_if;
  import axi_sram_slave_pkg::*;

  logic [AXI_ID_W-1:0]    ARID;
  logic [AXI_ADDR_W-1:0]  ARADDR;
  logic [AXI_LEN_W-1:0]   ARLEN;
  logic [AXI_SIZE_W-1:0]  ARSIZE;
  logic [AXI_BURST_W-1:0] ARBURST;
  logic                   ARVALID;
  logic                   ARREADY;

  logic [AXI_ID_W-1:0]    RID;
  logic [AXI_DATA_W-1:0]  RDATA;
  logic [AXI_RESP_W-1:0]  RRESP;
  logic                   RLAST;
  logic                   RVALID;
  logic                   RREADY;

  logic [AXI_ID_W-1:0]    AWID;
  logic [AXI_ADDR_W-1:0]  AWADDR;
  logic [AXI_LEN_W-1:0]   AWLEN;
  logic [AXI_SIZE_W-1:0]  AWSIZE;
  logic [AXI_BURST_W-1:0] AWBURST;
  logic                   AWVALID;
  logic                   AWREADY;

  logic [AXI_DATA_W-1:0]  WDATA;
  logic [AXI_STRB_W-1:0]  WSTRB;
  logic                   WLAST;
  logic                   WVALID;
  logic                   WREADY;

  logic [AXI_ID_W-1:0]    BID;
  logic [AXI_RESP_W-1:0]  BRESP;
  logic                   BVALID;
  logic                   BREADY;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

endinterface

// File: rtl/axi_sram_slave.sv
// Single-outstanding AXI4 slave bridging INCR read/write bursts (up to 16 beats) onto a
// single-port synchronous SRAM with one-cycle read latency.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int unsigned SRAM_AW = 14,
  parameter int unsigned DATA_W  = AXI_DATA_W
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axi_sram_slave_if.slave       axi,
  output logic                  CS,
  output logic                  OE,
  output logic [AXI_STRB_W-1:0] WEB,
  output logic [SRAM_AW-1:0]    A,
  output logic [DATA_W-1:0]     DI,
  input  logic [DATA_W-1:0]     DO
);

  slave_state_t          state_q, state_d;
  logic [AXI_ID_W-1:0]   id_q, id_d;
  logic [SRAM_AW-1:0]    a_q, a_d;
  logic [AXI_LEN_W-1:0]  cnt_q, cnt_d;

  // Size, burst type and address bits outside the SRAM word range carry no meaning here.
  logic unused_fields;
  assign unused_fields = ^{axi.ARSIZE, axi.ARBURST, axi.AWSIZE, axi.AWBURST,
                           axi.ARADDR, axi.AWADDR};

  // The SRAM address is the registered beat address, so it is stable across back-pressure.
  assign A = a_q;

  // State, ID, address and beat-count registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and channel/SRAM output decode.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    a_d         = a_q;
    cnt_d       = cnt_q;

    axi.ARREADY = 1'b0;
    axi.AWREADY = 1'b0;
    axi.RVALID  = 1'b0;
    axi.RID     = '0;
    axi.RDATA   = '0;
    axi.RRESP   = '0;
    axi.RLAST   = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    axi.BID     = '0;
    axi.BRESP   = '0;

    CS          = 1'b0;
    OE          = 1'b0;
    WEB         = '1;
    DI          = '0;

    unique case (state_q)
      S_IDLE: begin
        // Reads take priority when both address channels are valid together.
        axi.ARREADY = ARESETn;
        axi.AWREADY = ARESETn & ~axi.ARVALID;
        if (axi.ARVALID) begin
          id_d    = axi.ARID;
          a_d     = axi.ARADDR[SRAM_AW+1:2];
          cnt_d   = axi.ARLEN;
          state_d = S_RADDR;
        end else if (axi.AWVALID) begin
          id_d    = axi.AWID;
          a_d     = axi.AWADDR[SRAM_AW+1:2];
          state_d = S_WDATA;
        end
      end

      S_RADDR: begin
        CS      = 1'b1;
        OE      = 1'b1;
        state_d = S_RDATA;
      end

      S_RDATA: begin
        // Keep reading the same word so DO stays valid while RREADY is low.
        CS         = 1'b1;
        OE         = 1'b1;
        axi.RVALID = 1'b1;
        axi.RDATA  = AXI_DATA_W'(DO);
        axi.RID    = id_q;
        axi.RRESP  = RESP_OKAY;
        axi.RLAST  = is_last_beat(cnt_q);
        if (axi.RREADY) begin
          if (is_last_beat(cnt_q)) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q - AXI_LEN_W'(1);
            a_d     = a_q + SRAM_AW'(1);
            state_d = S_RADDR;
          end
        end
      end

      S_WDATA: begin
        axi.WREADY = 1'b1;
        CS         = 1'b1;
        DI         = DATA_W'(axi.WDATA);
        if (axi.WVALID) begin
          WEB = ~axi.WSTRB;
          a_d = a_q + SRAM_AW'(1);
          if (axi.WLAST) begin
            state_d = S_BRESP;
          end
        end
      end

      S_BRESP: begin
        axi.BVALID = 1'b1;
        axi.BID    = id_q;
        axi.BRESP  = RESP_OKAY;
        if (axi.BREADY) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised bench for axi_sram_slave: transaction-level model with a per-cycle compare
// process, plus directed scenarios pinned with literal expectations.
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;

  localparam int unsigned SRAM_AW = 14;
  localparam int unsigned DEPTH   = 1 << SRAM_AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi_sram_slave_if axi ();

  logic                CS, OE;
  logic [3:0]          WEB;
  logic [SRAM_AW-1:0]  A;
  logic [31:0]         DI, DO;

  axi_sram_slave #(.SRAM_AW(SRAM_AW), .DATA_W(32)) dut (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .axi     (axi),
    .CS      (CS),
    .OE      (OE),
    .WEB     (WEB),
    .A       (A),
    .DI      (DI),
    .DO      (DO)
  );

  logic [31:0] sram_mem [DEPTH];
  logic [31:0] ref_mem  [DEPTH];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] rd_buf [16];
  int          ar_hs_cyc, first_rv_cyc, rd_last_cyc, aw_hs_cyc;
  logic [3:0]  last_web;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no handshake within bound, expected one (t=%0t)", name, $time);
  endtask

  // Synchronous SRAM macro: byte-masked write, one-cycle registered read.
  always @(posedge clk) begin : sram_model
    logic [31:0] w;
    w = sram_mem[A];
    for (int b = 0; b < 4; b++) if (!WEB[b]) w[8*b +: 8] = DI[8*b +: 8];
    if (CS && (WEB != 4'hF)) sram_mem[A] <= w;
    if (CS && OE) DO <= sram_mem[A];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level reference state.
  logic               m_busy_rd, m_busy_wr, m_b_pend;
  logic [7:0]         m_rd_id, m_wr_id;
  logic [SRAM_AW-1:0] m_rd_addr, m_wr_addr;
  int                 m_rd_left, m_rv_at;

  // Compare process: at each falling edge, check what the next rising edge will see.
  always @(negedge clk) begin : monitor
    logic busy, ex_rv, r_hs, w_hs, b_hs, ar_hs, aw_hs;
    logic [3:0] ex_web;
    if (!rst_n) begin
      check32("rst_ctrl", 32'({axi.ARREADY, axi.AWREADY, axi.RVALID, axi.WREADY, axi.BVALID, CS, OE}), 32'h0);
      check32("rst_ids", 32'({axi.RID, axi.BID, axi.RRESP, axi.BRESP, axi.RLAST}), 32'h0);
      check32("rst_rdata", axi.RDATA, 32'h0);
      check32("rst_web", 32'(WEB), 32'hF);
      check32("rst_a", 32'(A), 32'h0);
      check32("rst_di", DI, 32'h0);
      m_busy_rd = 1'b0;
      m_busy_wr = 1'b0;
      m_b_pend  = 1'b0;
    end else begin
      busy  = m_busy_rd | m_busy_wr | m_b_pend;
      ex_rv = m_busy_rd && (cyc >= m_rv_at);
      check1("arready", axi.ARREADY, !busy);
      check1("awready", axi.AWREADY, !busy && !axi.ARVALID);
      check1("rvalid", axi.RVALID, ex_rv);
      if (ex_rv && axi.RVALID) begin
        check32("rdata", axi.RDATA, ref_mem[m_rd_addr]);
        check32("rid", 32'(axi.RID), 32'(m_rd_id));
        check1("rlast", axi.RLAST, m_rd_left == 1);
        check32("rresp", 32'(axi.RRESP), 32'h0);
      end
      if (m_busy_rd) check32("a_rd", 32'(A), 32'(m_rd_addr));
      check1("wready", axi.WREADY, m_busy_wr);
      ex_web = (m_busy_wr && axi.WVALID) ? ~axi.WSTRB : 4'hF;
      check32("web", 32'(WEB), 32'(ex_web));
      check1("cs", CS, m_busy_rd | m_busy_wr);
      check1("oe", OE, m_busy_rd);
      if (m_busy_wr && axi.WVALID) begin
        check32("a_wr", 32'(A), 32'(m_wr_addr));
        check32("di", DI, axi.WDATA);
      end
      check1("bvalid", axi.BVALID, m_b_pend);
      if (m_b_pend) begin
        check32("bid", 32'(axi.BID), 32'(m_wr_id));
        check32("bresp", 32'(axi.BRESP), 32'h0);
      end

      r_hs  = ex_rv && axi.RREADY;
      w_hs  = m_busy_wr && axi.WVALID;
      b_hs  = m_b_pend && axi.BREADY;
      ar_hs = !busy && axi.ARVALID;
      aw_hs = !busy && !axi.ARVALID && axi.AWVALID;

      if (r_hs) begin
        if (m_rd_left == 1) m_busy_rd = 1'b0;
        m_rd_left = m_rd_left - 1;
        m_rd_addr = m_rd_addr + SRAM_AW'(1);
        m_rv_at   = cyc + 2;
      end
      if (w_hs) begin
        for (int b = 0; b < 4; b++)
          if (axi.WSTRB[b]) ref_mem[m_wr_addr][8*b +: 8] = axi.WDATA[8*b +: 8];
        m_wr_addr = m_wr_addr + SRAM_AW'(1);
        if (axi.WLAST) begin
          m_busy_wr = 1'b0;
          m_b_pend  = 1'b1;
        end
      end
      if (b_hs) m_b_pend = 1'b0;
      if (ar_hs) begin
        m_busy_rd = 1'b1;
        m_rd_id   = axi.ARID;
        m_rd_addr = SRAM_AW'(axi.ARADDR >> 2);
        m_rd_left = int'(axi.ARLEN) + 1;
        m_rv_at   = cyc + 2;
      end
      if (aw_hs) begin
        m_busy_wr = 1'b1;
        m_wr_id   = axi.AWID;
        m_wr_addr = SRAM_AW'(axi.AWADDR >> 2);
      end
    end
  end

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len, input int mode);
    int t, beat;
    logic hs, stalled;
    logic [31:0] hold_d;
    logic hold_l;
    axi.ARID = id; axi.ARADDR = addr; axi.ARLEN = 4'(len);
    axi.ARSIZE = SIZE_4B; axi.ARBURST = BURST_INCR; axi.ARVALID = 1'b1;
    t = 0; hs = 1'b0; first_rv_cyc = -1;
    while (!hs && t < 100) begin
      @(negedge clk); hs = axi.ARREADY; if (hs) ar_hs_cyc = cyc;
      @(posedge clk); #1; t++;
    end
    axi.ARVALID = 1'b0;
    if (!hs) begin fail_timeout("ar_hs"); return; end
    @(negedge clk);
    check32("raddr_a", 32'(A), 32'(SRAM_AW'(addr >> 2)));
    check1("raddr_rvalid", axi.RVALID, 1'b0);
    @(posedge clk); #1;
    beat = 0; t = 0; stalled = 1'b0;
    while (beat <= len && t < 400) begin
      if (mode == 2 && beat == 1 && !stalled) begin
        axi.RREADY = 1'b0;
        @(negedge clk);
        while (!axi.RVALID && t < 400) begin @(posedge clk); #1; @(negedge clk); t++; end
        hold_d = axi.RDATA; hold_l = axi.RLAST;
        repeat (5) begin
          @(posedge clk); #1; @(negedge clk);
          check1("stall_rvalid", axi.RVALID, 1'b1);
          check32("stall_rdata", axi.RDATA, hold_d);
          check1("stall_rlast", axi.RLAST, hold_l);
        end
        @(posedge clk); #1;
        stalled = 1'b1;
      end
      axi.RREADY = (mode == 1) ? 1'($urandom % 2) : 1'b1;
      @(negedge clk);
      if (axi.RVALID && first_rv_cyc < 0) first_rv_cyc = cyc;
      if (axi.RVALID && axi.RREADY) begin
        rd_buf[beat] = axi.RDATA;
        if (axi.RLAST) rd_last_cyc = cyc;
        beat++;
      end
      @(posedge clk); #1; t++;
    end
    axi.RREADY = 1'b0;
    if (beat <= len) fail_timeout("r_beats");
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len, input int mode,
                          input logic [31:0] d0, input logic [3:0] s0, input int bdelay);
    int t;
    logic hs;
    axi.AWID = id; axi.AWADDR = addr; axi.AWLEN = 4'(len);
    axi.AWSIZE = SIZE_4B; axi.AWBURST = BURST_INCR; axi.AWVALID = 1'b1;
    t = 0; hs = 1'b0;
    while (!hs && t < 100) begin
      @(negedge clk); hs = axi.AWREADY; if (hs) aw_hs_cyc = cyc;
      @(posedge clk); #1; t++;
    end
    axi.AWVALID = 1'b0;
    if (!hs) begin fail_timeout("aw_hs"); return; end
    for (int i = 0; i <= len; i++) begin
      if (mode == 1 && ($urandom % 3) == 0) repeat ($urandom % 3) begin @(posedge clk); #1; end
      case (mode)
        0:       begin axi.WDATA = 32'(i + 1); axi.WSTRB = 4'hF; end
        1:       begin axi.WDATA = $urandom; axi.WSTRB = 4'($urandom); end
        default: begin axi.WDATA = d0; axi.WSTRB = s0; end
      endcase
      axi.WLAST = (i == len); axi.WVALID = 1'b1;
      t = 0; hs = 1'b0;
      while (!hs && t < 100) begin
        @(negedge clk); hs = axi.WREADY; if (hs) last_web = WEB;
        @(posedge clk); #1; t++;
      end
      axi.WVALID = 1'b0; axi.WLAST = 1'b0;
      if (!hs) begin fail_timeout("w_hs"); return; end
    end
    repeat (bdelay) begin @(posedge clk); #1; end
    axi.BREADY = 1'b1;
    t = 0; hs = 1'b0;
    while (!hs && t < 100) begin
      @(negedge clk); hs = axi.BVALID;
      @(posedge clk); #1; t++;
    end
    axi.BREADY = 1'b0;
    if (!hs) fail_timeout("b_hs");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected it to");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    int op, len;
    axi.ARVALID = 1'b0; axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = '0; axi.ARBURST = '0;
    axi.AWVALID = 1'b0; axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = '0; axi.AWBURST = '0;
    axi.WVALID = 1'b0; axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0;
    axi.RREADY = 1'b0; axi.BREADY = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    sram_mem[4] = 32'h1234_5678; ref_mem[4] = 32'h1234_5678;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read with literal data and two-cycle AR-to-RVALID latency.
    do_read(8'h05, 32'h0000_0010, 0, 0);
    check32("t1_rdata", rd_buf[0], 32'h1234_5678);
    check32("t1_latency", 32'(first_rv_cyc - ar_hs_cyc), 32'd2);

    // Four-beat write burst then read-back.
    do_write(8'h3C, 32'h0000_0020, 3, 0, 32'h0, 4'h0, 0);
    do_read(8'h07, 32'h0000_0020, 3, 0);
    for (int i = 0; i < 4; i++) check32($sformatf("t2_rd%0d", i), rd_buf[i], 32'(i + 1));

    // Byte-strobe merge.
    do_write(8'h31, 32'h0, 0, 2, 32'hAABB_CCDD, 4'hF, 0);
    do_write(8'h32, 32'h0, 0, 2, 32'h0000_1100, 4'b0010, 0);
    check32("t3_web", 32'(last_web), 32'hD);
    do_read(8'h33, 32'h0, 0, 0);
    check32("t3_rdata", rd_buf[0], 32'hAABB_11DD);

    // Simultaneous AR/AW: the write waits for the read's final beat.
    fork
      do_read(8'h11, 32'h0000_0100, 2, 0);
      do_write(8'h22, 32'h0000_0200, 1, 1, 32'h0, 4'h0, 0);
    join
    check32("t4_order", 32'(aw_hs_cyc), 32'(rd_last_cyc + 1));

    // Back-pressure on R and B.
    do_read(8'h41, 32'h0000_0300, 3, 2);
    do_write(8'h42, 32'h0000_0340, 1, 1, 32'h0, 4'h0, 7);

    // Address wrap at the top of the SRAM with junk upper address bits.
    do_read(8'h50, 32'h1234_FFF8, 3, 0);
    check32("wrap_rd2", rd_buf[2], 32'hAABB_11DD);

    // Reset asserted during the second beat of a four-beat write.
    axi.AWID = 8'h66; axi.AWADDR = 32'h0000_0400; axi.AWLEN = 4'd3;
    axi.AWSIZE = SIZE_4B; axi.AWBURST = BURST_INCR; axi.AWVALID = 1'b1;
    @(posedge clk); #1; axi.AWVALID = 1'b0;
    axi.WDATA = 32'hDEAD_0001; axi.WSTRB = 4'hF; axi.WLAST = 1'b0; axi.WVALID = 1'b1;
    @(posedge clk); #1;
    axi.WDATA = 32'hDEAD_0002;
    #2 rst_n = 1'b0;
    #1;
    check32("t6_imm_ctrl", 32'({axi.ARREADY, axi.AWREADY, axi.WREADY, axi.BVALID, CS}), 32'h0);
    check32("t6_imm_web", 32'(WEB), 32'hF);
    axi.WVALID = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_write(8'h77, 32'h0000_0800, 0, 2, 32'h0BAD_F00D, 4'hF, 0);
    do_read(8'h78, 32'h0000_0400, 1, 0);
    check32("t6_beat1", rd_buf[0], 32'hDEAD_0001);
    check32("t6_beat2", rd_buf[1], ref_mem[14'h101]);
    do_read(8'h79, 32'h0000_0800, 0, 0);
    check32("t6_after", rd_buf[0], 32'h0BAD_F00D);

    // Randomised traffic against the model.
    for (int it = 0; it < 40; it++) begin
      op   = int'($urandom % 3);
      len  = int'($urandom % 16);
      addr = $urandom;
      if (($urandom % 4) == 0)
        addr = (addr & ~32'h0000_FFFC) | (32'(DEPTH - 1 - ($urandom % 3)) << 2);
      case (op)
        0: do_read(8'($urandom), addr, len, int'($urandom % 2));
        1: do_write(8'($urandom), addr, len, 1, 32'h0, 4'h0, int'($urandom % 4));
        default: begin
          fork
            do_read(8'($urandom), addr, len, 1);
            do_write(8'($urandom), $urandom, int'($urandom % 16), 1, 32'h0, 4'h0, int'($urandom % 4));
          join
          check32("rand_order", 32'(aw_hs_cyc), 32'(rd_last_cyc + 1));
        end
      endcase
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
